// File: rtl/br_pkg.sv
// Shared definitions for the branch/jump execution pipeline: opcodes, funct3
// encodings and the bit layout of the packed instruction word.
package br_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int UOP_W  = 7;
  localparam int FUNC_W = 10;

  typedef enum logic [1:0] {
    K_NONE,
    K_BRANCH,
    K_JAL,
    K_JALR
  } br_kind_e;

  // Packed word, LSB first: op1, op2, rd, imm, PC, uop, brmask, func, valid.
  function automatic int off_op2(int xlen);
    return xlen;
  endfunction

  function automatic int off_rd(int xlen);
    return 2 * xlen;
  endfunction

  function automatic int off_imm(int xlen, int wreg);
    return 2 * xlen + wreg;
  endfunction

  function automatic int off_pc(int xlen, int wreg);
    return 3 * xlen + wreg;
  endfunction

  function automatic int off_uop(int xlen, int wreg);
    return 4 * xlen + wreg;
  endfunction

  function automatic int off_brm(int xlen, int wreg);
    return 4 * xlen + wreg + UOP_W;
  endfunction

  function automatic int off_func(int xlen, int wreg, int wbrm);
    return 4 * xlen + wreg + UOP_W + wbrm;
  endfunction

  function automatic int off_valid(int xlen, int wreg, int wbrm);
    return 4 * xlen + wreg + UOP_W + wbrm + FUNC_W;
  endfunction

  function automatic int instr_width(int xlen, int wreg, int wbrm);
    return 4 * xlen + wreg + wbrm + UOP_W + FUNC_W + 1;
  endfunction

  function automatic br_kind_e decode_kind(logic [6:0] uop);
    case (uop)
      OP_BRANCH: return K_BRANCH;
      OP_JAL:    return K_JAL;
      OP_JALR:   return K_JALR;
      default:   return K_NONE;
    endcase
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Combinational branch/jump resolution: condition compare, next-PC target,
// link value and mispredict detection against the predicted next PC.
module br_resolve
  import br_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int WIDTH_REG = 7
) (
  input  logic [6:0]           uop_i,
  input  logic [2:0]           funct3_i,
  input  logic [XLEN-1:0]      op1_i,
  input  logic [XLEN-1:0]      op2_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      pc_next_i,
  input  logic [WIDTH_REG-1:0] rd_i,
  output logic                 ok_o,
  output logic [XLEN-1:0]      target_o,
  output logic [XLEN-1:0]      link_o,
  output logic                 we_o,
  output logic                 mispredict_o
);

  br_kind_e        kind;
  logic            taken;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;

  assign kind        = decode_kind(uop_i);
  assign pc_plus_imm = pc_i + imm_i;
  assign jalr_sum    = op1_i + imm_i;
  assign link_o      = pc_i + XLEN'(4);

  always_comb begin
    taken = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken = (op1_i == op2_i);
      F3_BNE:  taken = (op1_i != op2_i);
      F3_BLT:  taken = ($signed(op1_i) <  $signed(op2_i));
      F3_BGE:  taken = ($signed(op1_i) >= $signed(op2_i));
      F3_BLTU: taken = (op1_i <  op2_i);
      F3_BGEU: taken = (op1_i >= op2_i);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target_o = link_o;
    case (kind)
      K_BRANCH: target_o = taken ? pc_plus_imm : link_o;
      K_JAL:    target_o = pc_plus_imm;
      K_JALR:   target_o = {jalr_sum[XLEN-1:1], 1'b0};
      default:  target_o = link_o;
    endcase
  end

  assign ok_o         = (kind != K_NONE);
  assign we_o         = ((kind == K_JAL) || (kind == K_JALR)) && (rd_i != '0);
  assign mispredict_o = (target_o != pc_next_i);

endmodule

// File: rtl/execute_br_pipe.sv
// Pipelined branch/jump execution unit. Every in-flight op keeps its branch
// mask current against the kill/clear broadcasts; results are registered.
module execute_br_pipe
  import br_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 4,
  parameter int STAGES    = 2,
  parameter int WIDTH     = 4*XLEN + WIDTH_REG + WIDTH_BRM + 7 + 10 + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_instr,
  input  logic [XLEN-1:0]      i_PCNext,
  input  logic [WIDTH_BRM-1:0] i_brtag,
  input  logic [WIDTH_BRM-1:0] i_kill_mask,
  input  logic [WIDTH_BRM-1:0] i_clr_mask,
  output logic                 o_valid,
  output logic                 o_we,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic [XLEN-1:0]      o_data,
  output logic [XLEN-1:0]      o_PC,
  output logic                 o_brkill,
  output logic                 o_brok,
  output logic [WIDTH_BRM-1:0] o_brmask
);

  localparam int F_OP2   = off_op2(XLEN);
  localparam int F_RD    = off_rd(XLEN);
  localparam int F_IMM   = off_imm(XLEN, WIDTH_REG);
  localparam int F_PC    = off_pc(XLEN, WIDTH_REG);
  localparam int F_UOP   = off_uop(XLEN, WIDTH_REG);
  localparam int F_BRM   = off_brm(XLEN, WIDTH_REG);
  localparam int F_FUNC  = off_func(XLEN, WIDTH_REG, WIDTH_BRM);
  localparam int F_VALID = off_valid(XLEN, WIDTH_REG, WIDTH_BRM);

  typedef struct packed {
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_next;
    logic [WIDTH_REG-1:0] rd;
    logic [6:0]           uop;
    logic [2:0]           funct3;
    logic [WIDTH_BRM-1:0] tag;
  } pay_t;

  pay_t                 in_pay;
  logic                 in_valid;
  logic [WIDTH_BRM-1:0] in_mask;
  logic [WIDTH_BRM-1:0] kill_or_clr;
  logic                 unused_func_hi;

  always_comb begin
    in_pay         = '0;
    in_pay.op1     = i_instr[0 +: XLEN];
    in_pay.op2     = i_instr[F_OP2 +: XLEN];
    in_pay.rd      = i_instr[F_RD +: WIDTH_REG];
    in_pay.imm     = i_instr[F_IMM +: XLEN];
    in_pay.pc      = i_instr[F_PC +: XLEN];
    in_pay.uop     = i_instr[F_UOP +: 7];
    in_pay.funct3  = i_instr[F_FUNC +: 3];
    in_pay.pc_next = i_PCNext;
    in_pay.tag     = i_brtag;
  end

  assign in_valid       = i_instr[F_VALID];
  assign in_mask        = i_instr[F_BRM +: WIDTH_BRM];
  assign kill_or_clr    = i_kill_mask | i_clr_mask;
  // Only funct3 matters to this unit; the upper func bits are don't-care.
  assign unused_func_hi = ^i_instr[F_FUNC+3 +: 7];

  // Op feeding the output register, after any intermediate stages.
  pay_t                 last_pay;
  logic                 last_valid;
  logic [WIDTH_BRM-1:0] last_mask;

  if (STAGES == 1) begin : g_direct
    assign last_pay   = in_pay;
    assign last_valid = in_valid;
    assign last_mask  = in_mask;
  end else begin : g_pipe
    pay_t                 pay_q   [STAGES-1];
    logic                 valid_q [STAGES-1];
    logic [WIDTH_BRM-1:0] mask_q  [STAGES-1];
    logic                 valid_d [STAGES-1];
    logic [WIDTH_BRM-1:0] mask_d  [STAGES-1];

    // Kill wins over clear: a killed op is dropped, so its mask no longer matters.
    always_comb begin
      valid_d[0] = in_valid && ((in_mask & i_kill_mask) == '0);
      mask_d[0]  = in_mask & ~kill_or_clr;
      for (int k = 1; k < STAGES - 1; k++) begin
        valid_d[k] = valid_q[k-1] && ((mask_q[k-1] & i_kill_mask) == '0);
        mask_d[k]  = mask_q[k-1] & ~kill_or_clr;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) valid_q[k] <= 1'b0;
      end else begin
        for (int k = 0; k < STAGES - 1; k++) valid_q[k] <= valid_d[k];
      end
      pay_q[0] <= in_pay;
      for (int k = 1; k < STAGES - 1; k++) pay_q[k] <= pay_q[k-1];
      for (int k = 0; k < STAGES - 1; k++) mask_q[k] <= mask_d[k];
    end

    assign last_pay   = pay_q[STAGES-2];
    assign last_valid = valid_q[STAGES-2];
    assign last_mask  = mask_q[STAGES-2];
  end

  logic            res_ok;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_we;
  logic            res_mispredict;

  br_resolve #(
    .XLEN      (XLEN),
    .WIDTH_REG (WIDTH_REG)
  ) u_resolve (
    .uop_i        (last_pay.uop),
    .funct3_i     (last_pay.funct3),
    .op1_i        (last_pay.op1),
    .op2_i        (last_pay.op2),
    .imm_i        (last_pay.imm),
    .pc_i         (last_pay.pc),
    .pc_next_i    (last_pay.pc_next),
    .rd_i         (last_pay.rd),
    .ok_o         (res_ok),
    .target_o     (res_target),
    .link_o       (res_link),
    .we_o         (res_we),
    .mispredict_o (res_mispredict)
  );

  logic                 fire_d;
  logic                 valid_d_out;
  logic                 we_d;
  logic [WIDTH_REG-1:0] addr_d;
  logic [XLEN-1:0]      data_d;
  logic [XLEN-1:0]      pc_d;
  logic                 brkill_d;
  logic                 brok_d;
  logic [WIDTH_BRM-1:0] brmask_d;

  assign fire_d = last_valid && ((last_mask & i_kill_mask) == '0) && res_ok;

  // Everything is forced to zero when nothing fires so idle cycles stay quiet.
  always_comb begin
    valid_d_out = fire_d;
    we_d        = fire_d && res_we;
    addr_d      = fire_d ? last_pay.rd : '0;
    data_d      = fire_d ? res_link : '0;
    pc_d        = fire_d ? res_target : '0;
    brkill_d    = fire_d && res_mispredict;
    brok_d      = fire_d && !res_mispredict;
    brmask_d    = fire_d ? last_pay.tag : '0;
  end

  logic                 valid_q;
  logic                 we_q;
  logic [WIDTH_REG-1:0] addr_q;
  logic [XLEN-1:0]      data_q;
  logic [XLEN-1:0]      pc_q;
  logic                 brkill_q;
  logic                 brok_q;
  logic [WIDTH_BRM-1:0] brmask_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pc_q     <= '0;
      brkill_q <= 1'b0;
      brok_q   <= 1'b0;
      brmask_q <= '0;
    end else begin
      valid_q  <= valid_d_out;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      brkill_q <= brkill_d;
      brok_q   <= brok_d;
      brmask_q <= brmask_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_we     = we_q;
  assign o_addr   = addr_q;
  assign o_data   = data_q;
  assign o_PC     = pc_q;
  assign o_brkill = brkill_q;
  assign o_brok   = brok_q;
  assign o_brmask = brmask_q;

endmodule
